// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the core-memory access sequencer: FSM state
// encoding, requester indices and default timing.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DECODE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef logic [1:0] rq_idx_t;

  localparam int      N_RQ  = 3;
  localparam rq_idx_t RQ_DA = 2'd0;
  localparam rq_idx_t RQ_OP = 2'd1;
  localparam rq_idx_t RQ_IF = 2'd2;

  localparam int DEF_ADDR_W     = 9;
  localparam int DEF_DEC_CYC    = 1;
  localparam int DEF_RD_CYC     = 2;
  localparam int DEF_WR_CYC     = 2;
  localparam int DEF_STARVE_MAX = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mem_prio_arb.sv
// Fixed-priority requester pick (DA > OP > IF). With STARVE_GUARD_EN defined, a
// run of DA grants made while OP/IF wait is counted and DA is skipped once at STARVE_MAX.
module mem_prio_arb
  import mem_seq_pkg::*;
`ifdef STARVE_GUARD_EN
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
)
`endif
(
`ifdef STARVE_GUARD_EN
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_take,
`endif
  input  logic [N_RQ-1:0] i_req,
  output logic            o_valid,
  output rq_idx_t         o_idx
);

  logic [N_RQ-1:0] w_req_eff;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_lower_pend;
  logic             w_da_masked;

  assign w_lower_pend = i_req[RQ_OP] | i_req[RQ_IF];
  assign w_da_masked  = w_lower_pend && (r_starve_cnt == CNT_W'(STARVE_MAX));

  // The run only means anything while someone below DA is actually waiting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (!w_lower_pend) begin
      r_starve_cnt <= '0;
    end else if (i_take) begin
      if (o_idx == RQ_DA) r_starve_cnt <= r_starve_cnt + 1'b1;
      else                r_starve_cnt <= '0;
    end
  end

  always_comb begin
    w_req_eff = i_req;
    if (w_da_masked) w_req_eff[RQ_DA] = 1'b0;
  end
`else
  assign w_req_eff = i_req;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a value held (no latch).
  always_comb begin
    o_valid = |w_req_eff;
    o_idx   = RQ_DA;
    if (w_req_eff[RQ_DA])      o_idx = RQ_DA;
    else if (w_req_eff[RQ_OP]) o_idx = RQ_OP;
    else if (w_req_eff[RQ_IF]) o_idx = RQ_IF;
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Grants the shared core-memory address register to DA/OP/IF and sequences one
// LOAD-DECODE-READ-WRITE-DONE core cycle per grant. Optional macro: STARVE_GUARD_EN.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEC_CYC    = DEF_DEC_CYC,
  parameter int RD_CYC     = DEF_RD_CYC,
  parameter int WR_CYC     = DEF_WR_CYC,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_da_req,
  input  logic [ADDR_W-1:0] i_da_adr,
  input  logic              i_da_wr,
  input  logic              i_op_req,
  input  logic [ADDR_W-1:0] i_op_adr,
  input  logic              i_op_wr,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_adr,
  input  logic              i_mem_inh,
  output logic              o_da_gnt,
  output logic              o_op_gnt,
  output logic              o_if_gnt,
  output logic              o_da_done,
  output logic              o_op_done,
  output logic              o_if_done,
  output logic              o_adr_ld,
  output logic [ADDR_W-1:0] o_adr,
  output logic              o_sel_en,
  output logic              o_rd_stb,
  output logic              o_wr_stb,
  output logic              o_wdat_sel,
  output logic              o_busy
);

  localparam int PH_W = $clog2(max3(DEC_CYC, RD_CYC, WR_CYC) + 1);

  if (DEC_CYC < 1 || RD_CYC < 1 || WR_CYC < 1 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_access_sequencer: timing and starvation parameters must be >= 1");
  end

  state_t            r_state, w_state_nx;
  logic [PH_W-1:0]   r_phase, w_phase_nx;
  rq_idx_t           r_owner;
  logic [ADDR_W-1:0] r_adr;
  logic              r_wr;

  logic [N_RQ-1:0]   w_req;
  logic              w_arb_valid;
  rq_idx_t           w_arb_idx;
  logic              w_take;
  logic [ADDR_W-1:0] w_win_adr;
  logic              w_win_wr;

  assign w_req = {i_if_req, i_op_req, i_da_req};

  mem_prio_arb
`ifdef STARVE_GUARD_EN
    #(.STARVE_MAX(STARVE_MAX))
`endif
    u_arb (
`ifdef STARVE_GUARD_EN
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_take  (w_take),
`endif
    .i_req   (w_req),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  // Fetch cycles never write new data, so their write flag is tied low here.
  always_comb begin
    w_win_adr = i_da_adr;
    w_win_wr  = i_da_wr;
    case (w_arb_idx)
      RQ_OP: begin
        w_win_adr = i_op_adr;
        w_win_wr  = i_op_wr;
      end
      RQ_IF: begin
        w_win_adr = i_if_adr;
        w_win_wr  = 1'b0;
      end
      default: ;
    endcase
  end

  // Timed states load N-1 on entry and leave when the phase count reaches zero.
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_take     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_arb_valid && !i_mem_inh) begin
          w_take     = 1'b1;
          w_state_nx = LOAD;
        end
      end
      LOAD: begin
        w_state_nx = DECODE;
        w_phase_nx = PH_W'(DEC_CYC - 1);
      end
      DECODE: begin
        if (r_phase == '0) begin
          w_state_nx = READ;
          w_phase_nx = PH_W'(RD_CYC - 1);
        end else begin
          w_phase_nx = r_phase - 1'b1;
        end
      end
      READ: begin
        if (r_phase == '0) begin
          w_state_nx = WRITE;
          w_phase_nx = PH_W'(WR_CYC - 1);
        end else begin
          w_phase_nx = r_phase - 1'b1;
        end
      end
      WRITE: begin
        if (r_phase == '0) w_state_nx = DONE;
        else               w_phase_nx = r_phase - 1'b1;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_owner <= RQ_DA;
      r_adr   <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      if (w_take) begin
        r_owner <= w_arb_idx;
        r_adr   <= w_win_adr;
        r_wr    <= w_win_wr;
      end
    end
  end

  // Outputs decode registered state only, so reset clears the strobes at once.
  always_comb begin
    o_da_gnt   = 1'b0;
    o_op_gnt   = 1'b0;
    o_if_gnt   = 1'b0;
    o_da_done  = 1'b0;
    o_op_done  = 1'b0;
    o_if_done  = 1'b0;
    if (r_state != IDLE) begin
      case (r_owner)
        RQ_DA:   o_da_gnt = 1'b1;
        RQ_OP:   o_op_gnt = 1'b1;
        RQ_IF:   o_if_gnt = 1'b1;
        default: ;
      endcase
    end
    if (r_state == DONE) begin
      o_da_done = o_da_gnt;
      o_op_done = o_op_gnt;
      o_if_done = o_if_gnt;
    end
    o_adr_ld   = (r_state == LOAD);
    o_sel_en   = (r_state == DECODE) || (r_state == READ) || (r_state == WRITE);
    o_rd_stb   = (r_state == READ);
    o_wr_stb   = (r_state == WRITE);
    o_wdat_sel = (r_state == WRITE) && r_wr;
    o_busy     = (r_state != IDLE);
  end

  assign o_adr = r_adr;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: vector table, multi-cycle corner
// sequences, and a done-time scoreboard with strobe-width monitor.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  localparam int ADDR_W     = 9;
  localparam int DEC_CYC    = 1;
  localparam int RD_CYC     = 2;
  localparam int WR_CYC     = 2;
  localparam int STARVE_MAX = 4;
  localparam int LOAD_TO_DONE = 1 + DEC_CYC + RD_CYC + WR_CYC;
  localparam int OWN_NONE   = 3;
  localparam int NV         = 8;

  logic clk = 1'b0;
  logic rst;
  logic da_req, da_wr, op_req, op_wr, if_req, mem_inh;
  logic [ADDR_W-1:0] da_adr, op_adr, if_adr;
  logic o_da_gnt, o_op_gnt, o_if_gnt, o_da_done, o_op_done, o_if_done;
  logic o_adr_ld, o_sel_en, o_rd_stb, o_wr_stb, o_wdat_sel, o_busy;
  logic [ADDR_W-1:0] o_adr;

  always #5 clk = ~clk;

  mem_access_sequencer #(
    .ADDR_W(ADDR_W), .DEC_CYC(DEC_CYC), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_da_req(da_req), .i_da_adr(da_adr), .i_da_wr(da_wr),
    .i_op_req(op_req), .i_op_adr(op_adr), .i_op_wr(op_wr),
    .i_if_req(if_req), .i_if_adr(if_adr), .i_mem_inh(mem_inh),
    .o_da_gnt(o_da_gnt), .o_op_gnt(o_op_gnt), .o_if_gnt(o_if_gnt),
    .o_da_done(o_da_done), .o_op_done(o_op_done), .o_if_done(o_if_done),
    .o_adr_ld(o_adr_ld), .o_adr(o_adr), .o_sel_en(o_sel_en),
    .o_rd_stb(o_rd_stb), .o_wr_stb(o_wr_stb), .o_wdat_sel(o_wdat_sel),
    .o_busy(o_busy)
  );

  typedef struct {
    int                owner;
    logic [ADDR_W-1:0] adr;
    logic              wsel;
  } exp_t;

  typedef struct {
    logic              da_req;
    logic [ADDR_W-1:0] da_adr;
    logic              da_wr;
    logic              op_req;
    logic [ADDR_W-1:0] op_adr;
    logic              op_wr;
    logic              if_req;
    logic [ADDR_W-1:0] if_adr;
    logic              inh;
    int                exp_owner;
    logic [ADDR_W-1:0] exp_adr;
    logic              exp_wsel;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int owner_of();
    if (o_da_gnt) return 0;
    if (o_op_gnt) return 1;
    if (o_if_gnt) return 2;
    return OWN_NONE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic idle_inputs();
    da_req = 1'b0; op_req = 1'b0; if_req = 1'b0; mem_inh = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (o_busy && n < max_cyc) begin
      tick();
      n++;
    end
    check({name, "_idle"}, o_busy, 1'b0);
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (!o_rd_stb && n < 20) begin
      tick();
      n++;
    end
    check({name, "_reach_read"}, o_rd_stb, 1'b1);
  endtask

  // Monitor: one-hot grant, strobe widths, LOAD-to-DONE distance, scoreboard at DONE.
  int   m_cyc, m_rd, m_wr, m_dn;
  logic m_wsel;
  logic [ADDR_W-1:0] m_adr;
  exp_t m_exp;

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_onehot", $countones({o_if_gnt, o_op_gnt, o_da_gnt}), o_busy ? 1 : 0);
      check("wsel_gate", o_wdat_sel & ~o_wr_stb, 1'b0);
      if (o_adr_ld) begin
        m_cyc = 0; m_rd = 0; m_wr = 0; m_wsel = 1'b0; m_adr = o_adr;
      end else if (o_busy) begin
        m_cyc++;
      end
      if (o_rd_stb) m_rd++;
      if (o_wr_stb) begin
        m_wr++;
        m_wsel = m_wsel | o_wdat_sel;
      end
      if (o_da_done | o_op_done | o_if_done) begin
        m_dn = o_da_done ? 0 : (o_op_done ? 1 : 2);
        check("done_onehot", $countones({o_if_done, o_op_done, o_da_done}), 1);
        check("done_vs_gnt", m_dn, owner_of());
        check("load_to_done", m_cyc, LOAD_TO_DONE);
        check("rd_width", m_rd, RD_CYC);
        check("wr_width", m_wr, WR_CYC);
        check("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          m_exp = sb_q.pop_front();
          check("sb_owner", m_dn, m_exp.owner);
          check("sb_adr", m_adr, m_exp.adr);
          check("sb_wdat_sel", m_wsel, m_exp.wsel);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nd;
    int   dcyc[3];
    int   ng;
    int   exp_own[6];
    logic [ADDR_W-1:0] vda, vop;

    vecs[0] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h155, 1'b1, 1'b0, 9'h000, 1'b0, 1, 9'h155, 1'b1};
    vecs[1] = '{1'b1, 9'h0AA, 1'b0, 1'b1, 9'h123, 1'b1, 1'b1, 9'h0F0, 1'b0, 0, 9'h0AA, 1'b0};
    vecs[2] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b1, 9'h001, 1'b0, 1, 9'h1FF, 1'b0};
    vecs[3] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h100, 1'b0, 2, 9'h100, 1'b0};
    vecs[4] = '{1'b1, 9'h1FF, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 0, 9'h1FF, 1'b1};
    vecs[5] = '{1'b1, 9'h000, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 9'h055, 1'b0, 0, 9'h000, 1'b1};
    vecs[6] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h0AB, 1'b1, 1'b0, 9'h000, 1'b1, OWN_NONE, 9'h000, 1'b0};
    vecs[7] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h1FE, 1'b0, 2, 9'h1FE, 1'b0};

    rst = 1'b1;
    idle_inputs();
    da_adr = '0; da_wr = 1'b0; op_adr = '0; op_wr = 1'b0; if_adr = '0;
    #1;
    check("rst_outputs", {o_da_gnt, o_op_gnt, o_if_gnt, o_da_done, o_op_done, o_if_done,
                          o_adr_ld, o_sel_en, o_rd_stb, o_wr_stb, o_wdat_sel, o_busy}, 0);
    check("rst_adr", o_adr, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", o_busy, 1'b0);

    // Table: one arbitration per entry, requests withdrawn once LOAD is seen.
    for (int i = 0; i < NV; i++) begin
      da_req = vecs[i].da_req; da_adr = vecs[i].da_adr; da_wr = vecs[i].da_wr;
      op_req = vecs[i].op_req; op_adr = vecs[i].op_adr; op_wr = vecs[i].op_wr;
      if_req = vecs[i].if_req; if_adr = vecs[i].if_adr; mem_inh = vecs[i].inh;
      if (vecs[i].exp_owner == OWN_NONE) begin
        repeat (3) tick();
        check($sformatf("v%0d_no_grant", i), {o_busy, o_da_gnt, o_op_gnt, o_if_gnt}, 0);
        idle_inputs();
        tick();
      end else begin
        sb_q.push_back('{vecs[i].exp_owner, vecs[i].exp_adr, vecs[i].exp_wsel});
        tick();
        check($sformatf("v%0d_gnt", i), owner_of(), vecs[i].exp_owner);
        check($sformatf("v%0d_adr_ld", i), o_adr_ld, 1'b1);
        check($sformatf("v%0d_adr", i), o_adr, vecs[i].exp_adr);
        idle_inputs();
        da_adr = ~da_adr; op_adr = ~op_adr; if_adr = ~if_adr;
        wait_idle($sformatf("v%0d", i), 20);
      end
    end

    // Simultaneous requests: DA, OP, IF served back-to-back, DONEs 8 clocks apart.
    da_req = 1'b1; da_adr = 9'h011; da_wr = 1'b1;
    op_req = 1'b1; op_adr = 9'h022; op_wr = 1'b0;
    if_req = 1'b1; if_adr = 9'h033;
    sb_q.push_back('{0, 9'h011, 1'b1});
    sb_q.push_back('{1, 9'h022, 1'b0});
    sb_q.push_back('{2, 9'h033, 1'b0});
    nd = 0;
    dcyc = '{0, 0, 0};
    for (int k = 0; k < 40 && nd < 3; k++) begin
      tick();
      if (o_da_gnt) da_req = 1'b0;
      if (o_op_gnt) op_req = 1'b0;
      if (o_if_gnt) if_req = 1'b0;
      if (o_da_done | o_op_done | o_if_done) begin
        dcyc[nd] = cyc_no;
        nd++;
      end
    end
    check("b2b_count", nd, 3);
    check("b2b_gap1", dcyc[1] - dcyc[0], LOAD_TO_DONE + 2);
    check("b2b_gap2", dcyc[2] - dcyc[1], LOAD_TO_DONE + 2);
    idle_inputs();
    wait_idle("b2b", 20);

    // Fetch request withdrawn during READ: cycle still finishes.
    if_req = 1'b1; if_adr = 9'h0C3;
    sb_q.push_back('{2, 9'h0C3, 1'b0});
    tick();
    check("ifdrop_load", o_if_gnt & o_adr_ld, 1'b1);
    wait_read("ifdrop");
    if_req = 1'b0;
    tick();
    check("ifdrop_gnt_held", o_if_gnt, 1'b1);
    wait_idle("ifdrop", 20);

    // MEM_INH blocks grants only from IDLE.
    mem_inh = 1'b1; op_req = 1'b1; op_adr = 9'h111; op_wr = 1'b1;
    repeat (3) tick();
    check("inh_blocks", o_busy, 1'b0);
    mem_inh = 1'b0;
    sb_q.push_back('{1, 9'h111, 1'b1});
    tick();
    check("inh_release_load", {o_adr_ld, o_op_gnt}, 2'b11);
    wait_read("inh_mid");
    mem_inh = 1'b1;
    op_req = 1'b0;
    wait_idle("inh_mid", 20);
    da_req = 1'b1;
    repeat (2) tick();
    check("inh_idle_block", o_busy, 1'b0);
    idle_inputs();
    tick();

    // Reset during WRITE clears outputs without a clock edge; held request restarts.
    da_req = 1'b1; da_adr = 9'h0F5; da_wr = 1'b1;
    sb_q.push_back('{0, 9'h0F5, 1'b1});
    tick();
    begin
      int n = 0;
      while (!o_wr_stb && n < 20) begin
        tick();
        n++;
      end
    end
    check("rstmid_reach_write", o_wr_stb, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_strobes", {o_wr_stb, o_sel_en, o_da_gnt, o_busy, o_wdat_sel}, 0);
    check("rstmid_adr", o_adr, 0);
    sb_q.delete();
    sb_q.push_back('{0, 9'h0F5, 1'b1});
    #1 rst = 1'b0;
    tick();
    check("rstmid_reload", {o_adr_ld, o_da_gnt}, 2'b11);
    check("rstmid_adr_again", o_adr, 9'h0F5);
    da_req = 1'b0;
    wait_idle("rstmid", 20);

    // DA and OP held: starvation guard lets OP through after STARVE_MAX DA grants.
    vda = 9'h0F0;
    vop = 9'h00F;
`ifdef STARVE_GUARD_EN
    exp_own = '{0, 0, 0, 0, 1, 0};
`else
    exp_own = '{0, 0, 0, 0, 0, 0};
`endif
    for (int j = 0; j < 6; j++)
      sb_q.push_back('{exp_own[j], (exp_own[j] == 0) ? vda : vop, (exp_own[j] == 0)});
    da_req = 1'b1; da_adr = vda; da_wr = 1'b1;
    op_req = 1'b1; op_adr = vop; op_wr = 1'b0;
    ng = 0;
    for (int k = 0; k < 100 && ng < 6; k++) begin
      tick();
      if (o_adr_ld) begin
        check($sformatf("starve_g%0d", ng), owner_of(), exp_own[ng]);
        ng++;
        if (ng == 6) idle_inputs();
      end
    end
    check("starve_grants", ng, 6);
    idle_inputs();
    wait_idle("starve", 20);

    tick();
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
